cic_decim_mch: RTL and testbench

CIC_DECIM_MCH -- requirements
Module: cic_decim_mch

---
 rtl/cic_decim_mch.sv | 177 +++++++++++++++++
 tb/tb_cic_decim_mch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_mch.sv
// cic_decim_mch
//   Multi-channel CIC decimator. CH unsigned input channels share one
//   decimation counter; each channel runs ORDER cascaded integrators at the
//   input strobe rate. On every decimation tick the last-stage integrators
//   are snapshotted, and a sequencer then pushes the channels one per clock
//   through a shared ORDER-stage comb (per-channel delay registers) into a
//   valid/ready output register.
//
// Ports
//   clock      : single clock, rising edge
//   sclr_n     : synchronous active-low reset
//   clock_ena  : input sample strobe
//   data       : CH packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   osr        : decimation ratio minus 1 (latched at frame start)
//   ready      : downstream accepts res
//   res        : decimated result (top RES_WIDTH bits of the comb output)
//   res_ch     : channel index of res
//   valid      : res/res_ch hold a result
//   overrun    : sticky, a snapshot was dropped because the previous one
//                had not been fully delivered
module cic_decim_mch #(
  parameter int CH         = 2,
  parameter int DATA_WIDTH = 10,
  parameter int OSR_WIDTH  = 7,
  parameter int ORDER      = 3,
  parameter int RES_WIDTH  = DATA_WIDTH,
  localparam int W         = ORDER * OSR_WIDTH + DATA_WIDTH,
  localparam int CW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                       clock,
  input  logic                       sclr_n,
  input  logic                       clock_ena,
  input  logic [CH*DATA_WIDTH-1:0]   data,
  input  logic [OSR_WIDTH-1:0]       osr,
  input  logic                       ready,
  output logic [RES_WIDTH-1:0]       res,
  output logic [CW-1:0]              res_ch,
  output logic                       valid,
  output logic                       overrun
);

  typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_t;

  logic [W-1:0]         integ     [CH][ORDER];
  logic [W-1:0]         integ_nxt [CH][ORDER];
  logic [W-1:0]         snap      [CH];
  logic [W-1:0]         comb_dly  [CH][ORDER];
  logic [W-1:0]         comb_in   [ORDER];
  logic [W-1:0]         comb_out;
  logic [OSR_WIDTH-1:0] cnt;
  logic [OSR_WIDTH-1:0] r_osr;
  seq_state_t           state, state_nxt;
  logic [CW-1:0]        seq_ch, seq_ch_nxt;
  logic                 tick, advance, accept, load;

  assign tick    = clock_ena && (cnt == r_osr);
  assign advance = !valid || ready;
  // A tick is only taken when every channel of the previous snapshot has
  // left (or is leaving on this very edge) the output register.
  assign accept  = tick && (state == SEQ_IDLE) && advance;
  assign load    = (state == SEQ_RUN) && advance;

  // Integrator cascade evaluated combinationally so a snapshot taken on the
  // tick edge already includes the tick sample.
  always_comb begin
    logic [W-1:0] acc;
    acc = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      acc = W'(data[c*DATA_WIDTH +: DATA_WIDTH]);
      for (int unsigned s = 0; s < ORDER; s++) begin
        acc = integ[c][s] + acc;
        integ_nxt[c][s] = acc;
      end
    end
  end

  // Shared comb chain for the channel currently being served.
  always_comb begin
    logic [W-1:0] v;
    v = snap[seq_ch];
    for (int unsigned s = 0; s < ORDER; s++) begin
      comb_in[s] = v;
      v = v - comb_dly[seq_ch][s];
    end
    comb_out = v;
  end

  // Sequencer state register
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      state  <= SEQ_IDLE;
      seq_ch <= '0;
    end else begin
      state  <= state_nxt;
      seq_ch <= seq_ch_nxt;
    end
  end

  // Sequencer next state
  always_comb begin
    state_nxt  = state;
    seq_ch_nxt = seq_ch;
    unique case (state)
      SEQ_IDLE: begin
        if (accept) begin
          state_nxt  = SEQ_RUN;
          seq_ch_nxt = '0;
        end
      end
      SEQ_RUN: begin
        if (advance) begin
          if (seq_ch == CW'(CH - 1)) begin
            state_nxt  = SEQ_IDLE;
            seq_ch_nxt = '0;
          end else begin
            seq_ch_nxt = seq_ch + 1'b1;
          end
        end
      end
      default: begin
        state_nxt  = SEQ_IDLE;
        seq_ch_nxt = '0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      for (int unsigned c = 0; c < CH; c++) begin
        snap[c] <= '0;
        for (int unsigned s = 0; s < ORDER; s++) begin
          integ[c][s]    <= '0;
          comb_dly[c][s] <= '0;
        end
      end
      cnt     <= '0;
      r_osr   <= osr;
      res     <= '0;
      res_ch  <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clock_ena) begin
        integ <= integ_nxt;
        if (tick) begin
          cnt   <= '0;
          r_osr <= osr;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (accept) begin
        for (int unsigned c = 0; c < CH; c++) begin
          snap[c] <= integ_nxt[c][ORDER-1];
        end
      end

      if (tick && !accept) begin
        overrun <= 1'b1;
      end

      if (load) begin
        for (int unsigned s = 0; s < ORDER; s++) begin
          comb_dly[seq_ch][s] <= comb_in[s];
        end
        res    <= comb_out[W-1 -: RES_WIDTH];
        res_ch <= seq_ch;
        valid  <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_mch.sv
module tb_cic_decim_mch;

  localparam int CH  = 2;
  localparam int DW  = 10;
  localparam int OW  = 7;
  localparam int ORD = 3;
  localparam int RW  = 10;
  localparam int W   = ORD * OW + DW;
  localparam int CW  = 1;
  localparam logic [63:0] MASK  = (64'd1 << W) - 64'd1;
  localparam logic [63:0] RMASK = (64'd1 << RW) - 64'd1;

  logic               clock = 1'b0;
  logic               sclr_n;
  logic               clock_ena;
  logic [CH*DW-1:0]   data;
  logic [OW-1:0]      osr;
  logic               ready;
  logic [RW-1:0]      res;
  logic [CW-1:0]      res_ch;
  logic               valid;
  logic               overrun;

  always #5 clock = ~clock;

  cic_decim_mch #(
    .CH(CH), .DATA_WIDTH(DW), .OSR_WIDTH(OW), .ORDER(ORD), .RES_WIDTH(RW)
  ) dut (
    .clock(clock), .sclr_n(sclr_n), .clock_ena(clock_ena), .data(data),
    .osr(osr), .ready(ready), .res(res), .res_ch(res_ch), .valid(valid),
    .overrun(overrun)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: running sums for the integrators, binomial N-th
  // difference over the accepted snapshot history for the combs, and a
  // scoreboard of results still owed to the downstream.
  logic [63:0] m_acc  [CH][ORD];
  logic [63:0] m_hist [CH][ORD+1];
  int unsigned m_cnt, m_R;
  bit          m_ovr, m_tick, m_took;
  int unsigned exp_ch[$];
  logic [63:0] exp_res[$];

  bit          last_xfer;
  int unsigned last_ch;
  logic [63:0] last_res;
  int unsigned cyc = 0;

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int s = 0; s < ORD; s++) m_acc[c][s] = '0;
      for (int j = 0; j <= ORD; j++) m_hist[c][j] = '0;
    end
    m_cnt = 0;
    m_R   = osr;
    m_ovr = 0;
    exp_ch.delete();
    exp_res.delete();
  endtask

  task automatic model_sample();
    for (int c = 0; c < CH; c++) begin
      logic [63:0] v;
      v = 64'(data[c*DW +: DW]);
      for (int s = 0; s < ORD; s++) begin
        m_acc[c][s] = (m_acc[c][s] + v) & MASK;
        v = m_acc[c][s];
      end
    end
    m_tick = (m_cnt == m_R);
    if (m_tick) begin
      m_cnt = 0;
      m_R   = osr;
      if (exp_ch.size() == 0) begin
        m_took = 1;
        for (int c = 0; c < CH; c++) begin
          longint y = 0;
          for (int j = ORD; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
          m_hist[c][0] = m_acc[c][ORD-1];
          for (int j = 0; j <= ORD; j++) begin
            if (j % 2 == 1) y = y - binom(ORD, j) * longint'(m_hist[c][j]);
            else            y = y + binom(ORD, j) * longint'(m_hist[c][j]);
          end
          exp_ch.push_back(c);
          exp_res.push_back(((64'(y) & MASK) >> (W - RW)) & RMASK);
        end
      end else begin
        m_ovr = 1;
      end
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: inputs are already set (we sit at a falling edge).
  task automatic step();
    last_xfer = 0;
    m_tick    = 0;
    m_took    = 0;
    if (sclr_n && valid && ready) begin
      last_xfer = 1;
      last_ch   = res_ch;
      last_res  = res;
      if (exp_ch.size() == 0) begin
        check_eq("spurious_valid", valid, 0);
      end else begin
        check_eq("res_ch", res_ch, exp_ch.pop_front());
        check_eq("res", res, exp_res.pop_front());
      end
    end
    if (!sclr_n) model_reset();
    else if (clock_ena) model_sample();
    @(posedge clock);
    #1;
    cyc++;
    if (!sclr_n) begin
      check_eq("rst_valid", valid, 0);
      check_eq("rst_res", res, 0);
      check_eq("rst_res_ch", res_ch, 0);
      check_eq("rst_overrun", overrun, 0);
    end else begin
      check_eq("overrun", overrun, m_ovr);
    end
    @(negedge clock);
  endtask

  task automatic reset_dut();
    sclr_n = 0;
    step();
    step();
    sclr_n = 1;
  endtask

  task automatic measure(input string tag, input int unsigned exp);
    int unsigned n = 0;
    bit seen = 0;
    sclr_n = 1; clock_ena = 1; ready = 1;
    while (!seen && n < 300) begin
      step();
      n++;
      if (valid) seen = 1;
    end
    check_eq(tag, n, exp);
  endtask

  task automatic wait_ch0(input string tag, output int unsigned t);
    bit found = 0;
    t = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (last_xfer && last_ch == 0) begin
        found = 1;
        t = cyc;
      end
    end
    check_eq(tag, found, 1);
  endtask

  task automatic drain(input string tag);
    clock_ena = 0; ready = 1; sclr_n = 1;
    for (int i = 0; i < 8; i++) step();
    check_eq(tag, exp_ch.size(), 0);
  endtask

  initial begin
    int unsigned n0, c0, t0, t1, t2;
    logic [RW-1:0] held, prev;
    logic [DW-1:0] d;
    logic [63:0] dq[$];

    sclr_n = 0; clock_ena = 0; data = '0; osr = 5; ready = 0;
    @(negedge clock);

    // Reset held with activity on every input, then first-result latency
    for (int i = 0; i < 10; i++) begin
      clock_ena = ~clock_ena;
      data  = (CH*DW)'($urandom);
      ready = 1'($urandom);
      step();
    end
    data = (CH*DW)'($urandom);
    measure("first_valid_osr5", 7);
    drain("drain_a");

    // DC at full ratio
    osr = 127;
    reset_dut();
    data = {10'd0, 10'd1023}; ready = 1; clock_ena = 1;
    n0 = 0; c0 = 0;
    for (int i = 0; i < 6*128 + 4; i++) begin
      step();
      if (last_xfer) begin
        if (last_ch == 0) begin
          n0++;
          if (n0 >= 4) begin
            check_eq("dc127_ch0", last_res, 1023);
            c0 = cyc;
          end
        end else if (n0 >= 4) begin
          check_eq("dc127_ch1", last_res, 0);
          check_eq("dc127_ch1_gap", cyc - c0, 1);
        end
      end
    end

    // Reduced ratio, then an osr change in the middle of a frame
    osr = 63;
    reset_dut();
    n0 = 0;
    for (int i = 0; i < 5*64 + 4; i++) begin
      step();
      if (last_xfer && last_ch == 0) begin
        n0++;
        if (n0 >= 4) check_eq("dc63_ch0", last_res, 127);
      end
    end
    wait_ch0("osr_wait0", t0);
    osr = 15;
    wait_ch0("osr_wait1", t1);
    wait_ch0("osr_wait2", t2);
    check_eq("osr_gap_old", t1 - t0, 64);
    check_eq("osr_gap_new", t2 - t1, 16);
    drain("drain_c");

    // Backpressure with a tick on every clock
    osr = 0; ready = 0;
    reset_dut();
    data = (CH*DW)'($urandom); clock_ena = 1;
    for (int i = 0; i < 6; i++) begin
      data = (CH*DW)'($urandom);
      step();
    end
    check_eq("bp_valid", valid, 1);
    check_eq("bp_ch", res_ch, 0);
    held = res;
    for (int i = 0; i < 4; i++) begin
      data = (CH*DW)'($urandom);
      step();
      check_eq("bp_hold_res", res, held);
      check_eq("bp_hold_ch", res_ch, 0);
      check_eq("bp_hold_valid", valid, 1);
    end
    check_eq("bp_overrun", overrun, 1);
    ready = 1;
    step();
    check_eq("bp_xfer0", last_xfer, 1);
    check_eq("bp_xfer0_ch", last_ch, 0);
    step();
    check_eq("bp_xfer1", last_xfer, 1);
    check_eq("bp_xfer1_ch", last_ch, 1);
    for (int i = 0; i < 20; i++) begin
      data = (CH*DW)'($urandom);
      step();
    end
    drain("drain_d");

    // Slow ramp over many integrator wraps
    osr = 127;
    reset_dut();
    d = DW'($urandom_range(100, 600));
    data = {d, d}; ready = 1;
    n0 = 0; prev = '0;
    for (int i = 0; i < 80*512; i++) begin
      clock_ena = (i % 4 == 0);
      step();
      if (m_tick) begin
        if (m_took) dq.push_back(64'(d));
        d = d + 1'b1;
        data = {d, d};
      end
      if (last_xfer && last_ch == 0 && dq.size() > 0) begin
        logic [63:0] dt;
        dt = dq.pop_front();
        n0++;
        if (n0 >= 4) begin
          check_eq("wrap_lag_1_to_2", (last_res + 1 == dt) || (last_res + 2 == dt), 1);
          check_eq("wrap_monotone", last_res >= 64'(prev), 1);
        end
        prev = RW'(last_res);
      end
    end
    drain("drain_e");

    // Reset while a result is held by backpressure
    osr = 9; ready = 0;
    reset_dut();
    clock_ena = 1;
    for (int i = 0; i < 50 && !valid; i++) step();
    check_eq("rm_valid_before", valid, 1);
    sclr_n = 0;
    step();
    measure("rm_first_valid", 11);
    drain("drain_f");

    // Random traffic
    osr = 3;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if (i % 97 == 0) osr = OW'($urandom_range(0, 7));
      clock_ena = ($urandom % 3) != 0;
      ready     = ($urandom % 4) != 0;
      data      = (CH*DW)'($urandom);
      sclr_n    = (i % 1000) != 999;
      step();
    end
    drain("drain_g");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
